// File: rtl/time_set_pkg.sv
// Shared definitions for the wall-clock time-setting controller:
// FSM states, BCD limits and capture validity helpers.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic [3:0] HOUR_MAX     = 4'd12;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_MAX      = 4'd9;

  // A 12-hour reading is 01..12 with a proper BCD units digit.
  function automatic logic hour_valid(input logic h1, input logic [3:0] h0);
    logic [4:0] hv;
    hv = (h1 ? 5'd10 : 5'd0) + {1'b0, h0};
    return (h0 <= BCD_MAX) && (hv != 5'd0) && (hv <= {1'b0, HOUR_MAX});
  endfunction

  function automatic logic min_valid(input logic [3:0] m1, input logic [3:0] m0);
    return (m1 <= MIN_TENS_MAX) && (m0 <= BCD_MAX);
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Pushbutton front end: two-flop synchronizer, stability counter and
// rising-edge press pulse on the accepted level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, then accept a new level only after an unbroken run of samples.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        press_r <= sync2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: captures the running time, lets the user step
// hours and minutes, then parallel-loads the counters with one strobe.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick,
  input  logic       qh1,
  input  logic [3:0] qh0,
  input  logic       qpm,
  input  logic [3:0] qm1,
  input  logic [3:0] qm0,
  output logic       dh1,
  output logic [3:0] dh0,
  output logic       dpm,
  output logic [3:0] dm1,
  output logic [3:0] dm0,
  output logic       load_n,
  output logic       sec_clr_n,
  output logic       hold,
  output logic       blank_h,
  output logic       blank_m
);

  logic       mode_p_s, inc_p_s;
  state_e     state_r, state_nxt_s;
  logic       dh1_r, dh1_nxt_s, dpm_r, dpm_nxt_s;
  logic [3:0] dh0_r, dh0_nxt_s, dm1_r, dm1_nxt_s, dm0_r, dm0_nxt_s;
  logic       phase_r, phase_nxt_s;
  logic       hold_r, load_n_r, blank_h_r, blank_m_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .clr(clr), .btn(btn_mode), .press(mode_p_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .clr(clr), .btn(btn_inc), .press(inc_p_s)
  );

  // Next state and shadow update; MODE outranks INC when both pulse together.
  always_comb begin
    state_nxt_s = state_r;
    dh1_nxt_s   = dh1_r;
    dh0_nxt_s   = dh0_r;
    dpm_nxt_s   = dpm_r;
    dm1_nxt_s   = dm1_r;
    dm0_nxt_s   = dm0_r;
    case (state_r)
      RUN: begin
        if (mode_p_s) begin
          state_nxt_s = SET_H;
          dpm_nxt_s   = qpm;
          if (hour_valid(qh1, qh0)) begin
            dh1_nxt_s = qh1;
            dh0_nxt_s = qh0;
          end else begin
            dh1_nxt_s = 1'b1;
            dh0_nxt_s = 4'd2;
          end
          if (min_valid(qm1, qm0)) begin
            dm1_nxt_s = qm1;
            dm0_nxt_s = qm0;
          end else begin
            dm1_nxt_s = 4'd0;
            dm0_nxt_s = 4'd0;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      SET_H: begin
        if (mode_p_s) begin
          state_nxt_s = SET_M;
        end else if (inc_p_s) begin
          if (dh1_r && (dh0_r == 4'd2)) begin
            dh1_nxt_s = 1'b0;
            dh0_nxt_s = 4'd1;
          end else if (dh1_r && (dh0_r == 4'd1)) begin
            dh0_nxt_s = 4'd2;
            dpm_nxt_s = ~dpm_r;
          end else if (!dh1_r && (dh0_r == BCD_MAX)) begin
            dh1_nxt_s = 1'b1;
            dh0_nxt_s = 4'd0;
          end else begin
            dh0_nxt_s = dh0_r + 4'd1;
          end
        end else begin
          state_nxt_s = SET_H;
        end
      end
      SET_M: begin
        if (mode_p_s) begin
          state_nxt_s = COMMIT;
        end else if (inc_p_s) begin
          if (dm0_r == BCD_MAX) begin
            dm0_nxt_s = 4'd0;
            if (dm1_r == MIN_TENS_MAX) begin
              dm1_nxt_s = 4'd0;
            end else begin
              dm1_nxt_s = dm1_r + 4'd1;
            end
          end else begin
            dm0_nxt_s = dm0_r + 4'd1;
          end
        end else begin
          state_nxt_s = SET_M;
        end
      end
      COMMIT:  state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // Blink phase restarts visible on entering a setting state, even over a TICK.
  always_comb begin
    if ((state_nxt_s != state_r) && ((state_nxt_s == SET_H) || (state_nxt_s == SET_M))) begin
      phase_nxt_s = 1'b1;
    end else if (tick) begin
      phase_nxt_s = ~phase_r;
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // State, shadow time and outputs registered from their next values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r   <= RUN;
      dh1_r     <= 1'b1;
      dh0_r     <= 4'd2;
      dpm_r     <= 1'b0;
      dm1_r     <= 4'd0;
      dm0_r     <= 4'd0;
      phase_r   <= 1'b1;
      hold_r    <= 1'b0;
      load_n_r  <= 1'b1;
      blank_h_r <= 1'b0;
      blank_m_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      dh1_r     <= dh1_nxt_s;
      dh0_r     <= dh0_nxt_s;
      dpm_r     <= dpm_nxt_s;
      dm1_r     <= dm1_nxt_s;
      dm0_r     <= dm0_nxt_s;
      phase_r   <= phase_nxt_s;
      hold_r    <= (state_nxt_s != RUN);
      load_n_r  <= (state_nxt_s != COMMIT);
      blank_h_r <= (state_nxt_s == SET_H) & ~phase_nxt_s;
      blank_m_r <= (state_nxt_s == SET_M) & ~phase_nxt_s;
    end
  end

  assign dh1       = dh1_r;
  assign dh0       = dh0_r;
  assign dpm       = dpm_r;
  assign dm1       = dm1_r;
  assign dm0       = dm0_r;
  assign load_n    = load_n_r;
  assign sec_clr_n = load_n_r;
  assign hold      = hold_r;
  assign blank_h   = blank_h_r;
  assign blank_m   = blank_m_r;

endmodule
